// File: rtl/fp_int_mac_pkg.sv
// fp_int_mac_pkg: FSM state encoding and FP16 exponent width shared by the MAC sequencer
package fp_int_mac_pkg;

    localparam int EXP_WIDTH = 5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SHIFT  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_RESULT = 3'd4
    } state_t;

endpackage

// File: rtl/fp_int_mac_wser.sv
// fp_int_mac_wser: load-and-shift weight serialiser, MSB (sign) first, flags the last bit
module fp_int_mac_wser #(
    parameter int PRECISION = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 shift,
    input  logic [PRECISION-1:0] din,
    output logic                 bit_out,
    output logic                 last_bit
);

    localparam int CW = $clog2(PRECISION) + 1;

    logic [PRECISION-1:0] sr_q, sr_d;
    logic [CW-1:0]        cnt_q, cnt_d;

    // load restarts the bit count; each shift exposes the next lower bit at the MSB
    always_comb begin
        sr_d  = load ? din : shift ? sr_q << 1 : sr_q;
        cnt_d = load ? '0 : shift ? cnt_q + CW'(1) : cnt_q;
    end

    // state registers, cleared by the asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    assign bit_out  = sr_q[PRECISION-1];
    assign last_bit = cnt_q == CW'(PRECISION - 1);

endmodule

// File: rtl/fp_int_mac_seq.sv
// fp_int_mac_seq: dot-product job sequencer feeding a bit-serial FP16 x INT MAC
module fp_int_mac_seq
    import fp_int_mac_pkg::*;
#(
    parameter int PRECISION = 4,
    parameter int ACT_WIDTH = 16,
    parameter int ACC_WIDTH = 32,
    parameter int LEN_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] vec_len,
    input  logic [EXP_WIDTH-1:0] exp_min,
    input  logic [ACC_WIDTH-1:0] acc_init,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ACT_WIDTH-1:0] in_act,
    input  logic [PRECISION-1:0] in_w,
    output logic                 mac_valid,
    output logic [ACT_WIDTH-1:0] mac_act,
    output logic                 mac_w,
    output logic [EXP_WIDTH-1:0] mac_exp_set,
    output logic [ACC_WIDTH-1:0] mac_acc,
    input  logic [EXP_WIDTH-1:0] mac_exp_out,
    input  logic [ACC_WIDTH-1:0] mac_acc_out,
    input  logic                 mac_done,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [EXP_WIDTH-1:0] res_exp,
    output logic [ACC_WIDTH-1:0] res_acc,
    output logic                 busy
);

    state_t               state_q, state_d;
    logic [ACT_WIDTH-1:0] act_q, act_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [EXP_WIDTH-1:0] exp_q, exp_d;
    logic [LEN_WIDTH-1:0] elem_cnt_q, elem_cnt_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic                 hs, shifting, ser_bit, last_bit;

    assign hs       = (state_q == ST_LOAD) && in_valid;
    assign shifting = state_q == ST_SHIFT;

    fp_int_mac_wser #(.PRECISION(PRECISION)) u_wser (
        .clk      (clk),
        .rst      (rst),
        .load     (hs),
        .shift    (shifting),
        .din      (in_w),
        .bit_out  (ser_bit),
        .last_bit (last_bit)
    );

    // next-state and operand/feedback register updates
    always_comb begin
        state_d    = state_q;
        act_d      = act_q;
        acc_d      = acc_q;
        exp_d      = exp_q;
        elem_cnt_d = elem_cnt_q;
        len_d      = len_q;
        case (state_q)
            ST_IDLE: if (start) begin
                state_d    = (vec_len == '0) ? ST_RESULT : ST_LOAD;
                acc_d      = acc_init;
                exp_d      = exp_min;
                elem_cnt_d = '0;
                len_d      = vec_len;
            end
            ST_LOAD: if (in_valid) begin
                state_d = ST_SHIFT;
                act_d   = in_act;
            end
            ST_SHIFT: state_d = last_bit ? ST_WAIT : ST_SHIFT;
            ST_WAIT: if (mac_done) begin
                acc_d      = mac_acc_out;
                exp_d      = mac_exp_out;
                elem_cnt_d = elem_cnt_q + LEN_WIDTH'(1);
                state_d    = (elem_cnt_q == len_q - LEN_WIDTH'(1)) ? ST_RESULT : ST_LOAD;
            end
            ST_RESULT: state_d = res_ready ? ST_IDLE : ST_RESULT;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM and datapath registers; reset abandons any job in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            act_q      <= '0;
            acc_q      <= '0;
            exp_q      <= '0;
            elem_cnt_q <= '0;
            len_q      <= '0;
        end else begin
            state_q    <= state_d;
            act_q      <= act_d;
            acc_q      <= acc_d;
            exp_q      <= exp_d;
            elem_cnt_q <= elem_cnt_d;
            len_q      <= len_d;
        end
    end

    assign in_ready    = state_q == ST_LOAD;
    assign mac_valid   = shifting;
    assign mac_w       = shifting & ser_bit;
    assign mac_act     = act_q;
    assign mac_acc     = acc_q;
    assign mac_exp_set = exp_q;
    assign res_valid   = state_q == ST_RESULT;
    assign res_acc     = acc_q;
    assign res_exp     = exp_q;
    assign busy        = state_q != ST_IDLE;

endmodule
